// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into press, short, long, repeat and
// release pulses. Ports: clk, rst_n, btn_level in; *_pulse and held out.
// Optional auto-repeat while long-held: define BTN_AUTO_REPEAT_EN.
module button_press_classifier #(
  parameter int unsigned          CNT_W         = 24,
  parameter logic [CNT_W-1:0]     LONG_CYCLES   = 24'd10000000,
  parameter logic [CNT_W-1:0]     REPEAT_CYCLES = 24'd2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - ONE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_d, short_d, long_d;
  logic             repeat_d, release_d, held_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = REPEAT_CYCLES - ONE;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_level && !btn_q) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        // release wins over a threshold hit on the same edge
        if (!btn_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          short_d   = 1'b1;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_q         <= btn_level;
      press_pulse   <= press_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      release_pulse <= release_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier, LONG=8, REPEAT=4.
// Outputs packed as {press, short, long, repeat, release, held}.
module tb_button_press_classifier;

  logic clk;
  logic rst_n;
  logic btn_level;
  logic press_pulse, short_pulse, long_pulse;
  logic repeat_pulse, release_pulse, held;

  int n_tests;
  int n_fail;

  button_press_classifier #(
    .CNT_W(24),
    .LONG_CYCLES(24'd8),
    .REPEAT_CYCLES(24'd4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .release_pulse(release_pulse),
    .held(held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {press_pulse, short_pulse, long_pulse,
            repeat_pulse, release_pulse, held};
  endfunction

  task automatic settle_idle();
    @(negedge clk);
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n     = 1'b0;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    got = outs();
    n_tests++;
    if (got !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset got=%b exp=%b", got, 6'b000000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = outs();
    n_tests++;
    if (got !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=%b", got, 6'b000000);
    end
  endtask

  // high for edges 0-2, low at edge 3
  task automatic test_short();
    logic [5:0] got, exp;
    @(negedge clk);
    btn_level = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      exp = 6'b0;
      if (e + 1 == 1) exp[5] = 1'b1;
      if (e + 1 == 4) begin exp[4] = 1'b1; exp[1] = 1'b1; end
      if (e + 1 >= 1 && e + 1 <= 3) exp[0] = 1'b1;
      got = outs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL short c=%0d got=%b exp=%b", e + 1, got, exp);
      end
      btn_level = (e + 1 <= 2);
    end
    settle_idle();
  endtask

  // high through edge 20, low at edge 21
  task automatic test_long();
    logic [5:0] got, exp;
    @(negedge clk);
    btn_level = 1'b1;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      exp = 6'b0;
      if (e + 1 == 1) exp[5] = 1'b1;
      if (e + 1 == 9) exp[3] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      if (e + 1 == 13 || e + 1 == 17 || e + 1 == 21) exp[2] = 1'b1;
`endif
      if (e + 1 == 22) exp[1] = 1'b1;
      if (e + 1 >= 1 && e + 1 <= 21) exp[0] = 1'b1;
      got = outs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL long c=%0d got=%b exp=%b", e + 1, got, exp);
      end
      btn_level = (e + 1 <= 20);
    end
    settle_idle();
  endtask

  // high for edges 0-7, low at edge 8: release beats threshold
  task automatic test_collision();
    logic [5:0] got, exp;
    @(negedge clk);
    btn_level = 1'b1;
    for (int e = 0; e < 11; e++) begin
      @(negedge clk);
      exp = 6'b0;
      if (e + 1 == 1) exp[5] = 1'b1;
      if (e + 1 == 9) begin exp[4] = 1'b1; exp[1] = 1'b1; end
      if (e + 1 >= 1 && e + 1 <= 8) exp[0] = 1'b1;
      got = outs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL collision c=%0d got=%b exp=%b", e + 1, got, exp);
      end
      btn_level = (e + 1 <= 7);
    end
    settle_idle();
  endtask

  // high 0-2, low 3, high 4-5, low 6: two full presses
  task automatic test_back_to_back();
    logic [5:0] got, exp;
    @(negedge clk);
    btn_level = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      exp = 6'b0;
      if (e + 1 == 1 || e + 1 == 5) exp[5] = 1'b1;
      if (e + 1 == 4 || e + 1 == 7) begin exp[4] = 1'b1; exp[1] = 1'b1; end
      if ((e + 1 >= 1 && e + 1 <= 3) || e + 1 == 5 || e + 1 == 6) exp[0] = 1'b1;
      got = outs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b c=%0d got=%b exp=%b", e + 1, got, exp);
      end
      btn_level = (e + 1 <= 2) || (e + 1 == 4) || (e + 1 == 5);
    end
    settle_idle();
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] got, exp;
    @(negedge clk);
    btn_level = 1'b1;
    repeat (5) @(negedge clk);
    got = outs();
    n_tests++;
    if (got !== 6'b000001) begin
      n_fail++;
      $display("FAIL midrst_pre got=%b exp=%b", got, 6'b000001);
    end
    #2 rst_n = 1'b0;
    #1 got = outs();
    n_tests++;
    if (got !== 6'b000000) begin
      n_fail++;
      $display("FAIL midrst_async got=%b exp=%b", got, 6'b000000);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = (c == 1) ? 6'b100001 : 6'b000001;
      got = outs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midrst_after c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    btn_level = 1'b0;
    @(negedge clk);
    got = outs();
    n_tests++;
    if (got !== 6'b010010) begin
      n_fail++;
      $display("FAIL midrst_release got=%b exp=%b", got, 6'b010010);
    end
    settle_idle();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    btn_level = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_collision();
    test_back_to_back();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
